byte_packer: RTL and testbench
==============================

BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 8, meaning bits per input beat.
REQ-002 The block SHALL have parameter RATIO, default 4, meaning input beats per output word; legal values are powers of two, at least 2.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  an input beat is offered; driven by the read side of the async FIFO (valid_r).
REQ-006 The block SHALL have port in_ready  output  1  the beat is accepted this cycle; drives the FIFO read enable (ready_r).
REQ-007 The block SHALL have port in_data  input  IN_WIDTH  the input beat.
REQ-008 The block SHALL have port flush  input  1  single-cycle request to emit the current partial word.
REQ-009 The block SHALL have port out_valid  output  1  out_data and out_keep are valid.
REQ-010 The block SHALL have port out_ready  input  1  the consumer accepts the output word.
REQ-011 The block SHALL have port out_data  output  IN_WIDTH*RATIO  the packed word.
REQ-012 The block SHALL have port out_keep  output  RATIO  one bit per lane, set where the lane holds a real beat.

Function
REQ-013 An input accept SHALL occur when in_valid and in_ready are both high at a rising edge; an output handshake SHALL occur when out_valid and out_ready are both high.
REQ-014 Beats SHALL be packed little-endian: the first beat of a word goes to lane 0 (bits IN_WIDTH-1:0), and each later beat goes to the next lane.
REQ-015 The accumulator SHALL hold a count cnt in the range 0..RATIO-1 and partial data; cnt SHALL increment on every accept and wrap to 0 when a word completes.
REQ-016 Output free condition: out_free = ~out_valid | out_ready.
REQ-017 When the FSM is in ACCUM, in_ready SHALL equal (cnt != RATIO-1) | out_free; this is a combinational path from out_ready.
REQ-018 When a beat is accepted with cnt == RATIO-1, the output register SHALL load the completed word with out_keep set to all ones, and out_valid SHALL be high in the next cycle (latency 1).
REQ-019 The output register SHALL NOT change while out_valid is high and out_ready is low.
REQ-020 The FSM SHALL have two states, ACCUM and FLUSH_WAIT.
REQ-021 On flush in ACCUM, the effective count SHALL be cnt plus 1 if a beat is accepted in the same cycle, otherwise cnt.
REQ-022 If the effective count is 0, or the same-cycle accept completes a full word, flush SHALL be a no-op.
REQ-023 If the effective count is between 1 and RATIO-1 and out_free is high, the output register SHALL load the partial word in the same edge and cnt SHALL go to 0.
REQ-024 If the effective count is between 1 and RATIO-1 and out_free is low, the FSM SHALL move to FLUSH_WAIT.
REQ-025 In FLUSH_WAIT, in_ready SHALL be 0 and flush SHALL be ignored; when out_free is high, the partial word SHALL load, cnt SHALL go to 0, and the FSM SHALL return to ACCUM.
REQ-026 For a partial word, out_keep SHALL have its low effective-count bits set; unfilled lanes of out_data SHALL be zero.
REQ-027 Output handshakes SHALL deliver every accepted beat exactly once, in order, with no duplication or loss.

Reset
REQ-028 While rst is low, the block SHALL set out_valid=0, out_data=0, out_keep=0, cnt=0, accumulator data 0, and FSM=ACCUM, independent of clk.
REQ-029 During and after reset, in_ready SHALL be 1.
REQ-030 If reset is asserted mid-word, the partial data SHALL be discarded, with no output pulse on release.

Structure
REQ-031 The FSM state enum SHALL be defined in the shared package ucie_pkg as pack_state_t {ACCUM, FLUSH_WAIT}.
REQ-032 The lane-index width $clog2(RATIO) SHALL be derived locally.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 Scenario: reset, then beats 0x11,0x22,0x33,0x44 back-to-back with out_ready=1 -> out_valid for exactly 1 cycle, starting the cycle after the 4th accept, with out_data=0x44332211 and out_keep=4'b1111.
REQ-035 Scenario: out_ready=0 with 8 beats 0x01..0x08 offered -> first word 0x04030201 held stable; in_ready drops with cnt=3; out_ready=1 then delivers 0x04030201 then 0x08070605.
REQ-036 Scenario: beats 0xAA,0xBB, then a flush pulse with out_ready=1 -> out_data=0x0000BBAA, out_keep=4'b0011, then cnt=0.
REQ-037 Scenario: flush in the same cycle as accepting the 3rd beat 0xCC after 0xAA,0xBB -> out_data=0x00CCBBAA, out_keep=4'b0111; flush in the same cycle as the 4th beat -> a single full word, no extra output.
REQ-038 Scenario: 1 beat, then flush while out_valid is high and out_ready=0 -> FLUSH_WAIT with in_ready=0; raising out_ready delivers the pending word and then the partial word (out_keep=4'b0001).
REQ-039 Scenario: assert rst after 2 beats with out_valid high -> all outputs 0 immediately; the next 4 beats 0x01..0x04 give 0x04030201 only.

Source files
------------

// File: rtl/ucie_pkg.sv
// ---------------------------------------------------------------------------
// ucie_pkg
// Shared types and defaults for the byte packer datapath.
//   pack_state_t      : control state of the packer (ACCUM / FLUSH_WAIT)
//   PACK_IN_WIDTH_DEF : default bits per input beat
//   PACK_RATIO_DEF    : default input beats per packed output word
// ---------------------------------------------------------------------------
package ucie_pkg;

  localparam int PACK_IN_WIDTH_DEF = 8;
  localparam int PACK_RATIO_DEF    = 4;

  typedef enum logic [0:0] {
    ACCUM      = 1'b0,
    FLUSH_WAIT = 1'b1
  } pack_state_t;

endpackage : ucie_pkg

// File: rtl/byte_packer_if.sv
// ---------------------------------------------------------------------------
// byte_packer_if
// Bundles the narrow input stream, the flush request and the wide output
// stream of the byte packer.
//   in_valid/in_ready/in_data : narrow beat stream (FIFO read side)
//   flush                     : one-cycle request to emit the partial word
//   out_valid/out_ready       : wide word handshake
//   out_data/out_keep         : packed word and per-lane occupancy mask
// Modports:
//   slave  : the packer itself
//   master : the environment (beat source + word consumer)
// ---------------------------------------------------------------------------
interface byte_packer_if
  import ucie_pkg::*;
#(
  parameter int IN_WIDTH = PACK_IN_WIDTH_DEF,
  parameter int RATIO    = PACK_RATIO_DEF
);

  logic                      in_valid;
  logic                      in_ready;
  logic [IN_WIDTH-1:0]       in_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [IN_WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]          out_keep;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );

endinterface : byte_packer_if

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Packs RATIO narrow beats of IN_WIDTH bits into one wide word, little-endian
// (first beat in lane 0). A flush pulse emits the current partial word with
// out_keep marking the filled lanes; unfilled lanes read as zero. If the
// output register is still occupied when a flush arrives, the packer parks in
// FLUSH_WAIT (input stalled) until the register frees up.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : byte_packer_if.slave (input stream, flush, output stream)
// ---------------------------------------------------------------------------
module byte_packer
  import ucie_pkg::*;
#(
  parameter int IN_WIDTH = PACK_IN_WIDTH_DEF,
  parameter int RATIO    = PACK_RATIO_DEF
) (
  input logic          clk,
  input logic          rst,
  byte_packer_if.slave bus
);

  localparam int                LANE_W    = $clog2(RATIO);
  localparam int                OUT_W     = IN_WIDTH * RATIO;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  pack_state_t       state_q, state_d;
  logic [LANE_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [RATIO-1:0]  out_keep_q, out_keep_d;

  logic              out_free;
  logic              in_ready;
  logic              accept;
  logic              word_done;
  logic [LANE_W:0]   eff_cnt;
  logic [OUT_W-1:0]  acc_merged;
  logic [RATIO-1:0]  eff_keep;
  logic [RATIO-1:0]  cnt_keep;

  // The last lane can only be accepted if the completed word has somewhere
  // to go this very edge, hence the combinational path from out_ready.
  assign out_free  = ~out_valid_q | bus.out_ready;
  assign in_ready  = (state_q == ACCUM) && ((cnt_q != LAST_LANE) || out_free);
  assign accept    = bus.in_valid & in_ready;
  assign word_done = accept && (cnt_q == LAST_LANE);
  assign eff_cnt   = {1'b0, cnt_q} + {{LANE_W{1'b0}}, accept};

  // Accumulator contents including a beat accepted this cycle. Lanes above
  // the fill point are always zero because the accumulator is cleared
  // whenever a word leaves it.
  always_comb begin : merge_beat
    acc_merged = acc_q;
    if (accept) begin
      acc_merged[cnt_q*IN_WIDTH +: IN_WIDTH] = bus.in_data;
    end
  end

  always_comb begin : keep_masks
    eff_keep = '0;
    cnt_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      eff_keep[i] = (i < int'(eff_cnt));
      cnt_keep[i] = (i < int'(cnt_q));
    end
  end

  always_comb begin : next_state
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_merged;
          cnt_d = cnt_q + 1'b1;
        end
        if (word_done) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_merged;
          out_keep_d  = '1;
          acc_d       = '0;
          cnt_d       = '0;
        end else if (bus.flush && (eff_cnt != '0)) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_merged;
            out_keep_d  = eff_keep;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            // acc_d/cnt_d already hold any same-cycle beat.
            state_d = FLUSH_WAIT;
          end
        end
      end

      FLUSH_WAIT: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_keep_d  = cnt_keep;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ACCUM;
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  // NOTE: the accumulator is datapath, but it is reset as well so a word
  // interrupted by reset can never leak stale lanes into a later partial.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;

endmodule : byte_packer

// File: tb/tb_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_byte_packer
// Self-checking bench for byte_packer (IN_WIDTH=8, RATIO=4). A queue-based
// model of accepted beats and the pending output word is compared with the
// DUT on every falling edge; directed scenarios pin the model with literal
// words, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_byte_packer;

  localparam int IW = 8;
  localparam int R  = 4;

  typedef struct packed {
    logic [IW*R-1:0] data;
    logic [R-1:0]    keep;
  } word_t;

  logic clk;
  logic rst;

  byte_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus ();

  byte_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [IW-1:0] cur[$];      // beats of the word being collected
  word_t         oq[$];       // word sitting in the output register (0 or 1)
  bit            pending;     // partial word waiting for the output register
  word_t         dlog[$];     // words actually handed to the consumer
  int            n_acc;       // beats accepted since last reset
  int            n_lanes;     // filled lanes delivered since last reset

  function automatic word_t make_word();
    word_t w;
    w.data = '0;
    for (int i = 0; i < cur.size(); i++) w.data |= 32'(cur[i]) << (IW * i);
    w.keep = 4'((1 << cur.size()) - 1);
    return w;
  endfunction

  initial begin : model
    bit mv, ofree, eir, acc;
    pending = 0;
    n_acc   = 0;
    n_lanes = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur.delete();
        oq.delete();
        pending = 0;
        n_acc   = 0;
        n_lanes = 0;
      end
      mv    = (oq.size() != 0);
      ofree = !mv || bus.out_ready;
      eir   = !pending && ((cur.size() != R - 1) || ofree);
      check("in_ready", bus.in_ready, eir);
      check("out_valid", bus.out_valid, mv);
      if (mv && bus.out_valid) begin
        check("out_data", bus.out_data, oq[0].data);
        check("out_keep", bus.out_keep, oq[0].keep);
      end
      if (rst) begin
        if (bus.out_valid && bus.out_ready) begin
          word_t w;
          w.data = bus.out_data;
          w.keep = bus.out_keep;
          dlog.push_back(w);
          n_lanes += $countones(bus.out_keep);
        end
        acc = bus.in_valid && eir;
        if (mv && bus.out_ready) void'(oq.pop_front());
        if (pending) begin
          if (ofree) begin
            oq.push_back(make_word());
            cur.delete();
            pending = 0;
          end
        end else begin
          if (acc) begin
            cur.push_back(bus.in_data);
            n_acc++;
          end
          if (acc && cur.size() == R) begin
            oq.push_back(make_word());
            cur.delete();
          end else if (bus.flush && cur.size() != 0) begin
            if (ofree) begin
              oq.push_back(make_word());
              cur.delete();
            end else begin
              pending = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [IW-1:0] b, input bit fl);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.flush    = fl;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] d, input logic [3:0] k);
    if (idx < dlog.size()) begin
      check({name, "_data"}, dlog[idx].data, d);
      check({name, "_keep"}, dlog[idx].keep, k);
    end else begin
      check({name, "_missing"}, dlog.size(), idx + 1);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : stim
    int n0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_keep", bus.out_keep, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b1;
    idle(1);

    // Full word, back to back, consumer ready.
    n0 = dlog.size();
    drive_beat(8'h11, 0);
    drive_beat(8'h22, 0);
    drive_beat(8'h33, 0);
    drive_beat(8'h44, 0);
    check("full_valid_next", bus.out_valid, 1);
    check("full_data_next", bus.out_data, 32'h44332211);
    idle(1);
    check("full_valid_one_cycle", bus.out_valid, 0);
    check("full_count", dlog.size() - n0, 1);
    check_log("full", n0, 32'h44332211, 4'b1111);

    // Back-pressure: 8 beats with consumer stalled.
    n0 = dlog.size();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) drive_beat(IW'(i), 0);
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_hold_data", bus.out_data, 32'h04030201);
    idle(2);
    check("bp_hold_data_later", bus.out_data, 32'h04030201);
    check("bp_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    drive_beat(8'h08, 0);
    idle(2);
    check_log("bp_w0", n0, 32'h04030201, 4'b1111);
    check_log("bp_w1", n0 + 1, 32'h08070605, 4'b1111);

    // Flush of a two-beat partial.
    n0 = dlog.size();
    drive_beat(8'hAA, 0);
    drive_beat(8'hBB, 0);
    pulse_flush();
    idle(2);
    check_log("flush2", n0, 32'h0000BBAA, 4'b0011);
    for (int i = 1; i <= 4; i++) drive_beat(IW'(i), 0);
    idle(2);
    check_log("after_flush_aligned", n0 + 1, 32'h04030201, 4'b1111);

    // Flush together with the 3rd beat, then together with the 4th.
    n0 = dlog.size();
    drive_beat(8'hAA, 0);
    drive_beat(8'hBB, 0);
    drive_beat(8'hCC, 1);
    idle(2);
    check_log("flush3_same", n0, 32'h00CCBBAA, 4'b0111);
    drive_beat(8'h11, 0);
    drive_beat(8'h22, 0);
    drive_beat(8'h33, 0);
    drive_beat(8'h44, 1);
    idle(3);
    check("flush4_single_word", dlog.size() - n0, 2);
    check_log("flush4_same", n0 + 1, 32'h44332211, 4'b1111);

    // Flush while the output register is blocked.
    n0 = dlog.size();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive_beat(IW'(i), 0);
    drive_beat(8'h55, 0);
    pulse_flush();
    check("fw_in_ready_low", bus.in_ready, 0);
    idle(2);
    check("fw_in_ready_still_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    idle(3);
    check("fw_in_ready_back", bus.in_ready, 1);
    check_log("fw_pending", n0, 32'h04030201, 4'b1111);
    check_log("fw_partial", n0 + 1, 32'h00000055, 4'b0001);

    // Reset mid-word with a word parked in the output register.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive_beat(IW'(i), 0);
    drive_beat(8'h0A, 0);
    drive_beat(8'h0B, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_data", bus.out_data, 0);
    check("async_rst_keep", bus.out_keep, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    n0 = dlog.size();
    idle(2);
    check("no_pulse_after_rst", dlog.size() - n0, 0);
    for (int i = 1; i <= 4; i++) drive_beat(IW'(i), 0);
    idle(3);
    check("post_rst_count", dlog.size() - n0, 1);
    check_log("post_rst", n0, 32'h04030201, 4'b1111);

    // Randomized traffic: light then heavy consumer back-pressure.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 3000; c++) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_data   = IW'($urandom);
        bus.flush     = ($urandom_range(0, 11) == 0);
        bus.out_ready = (phase == 0) ? ($urandom_range(0, 3) != 0)
                                     : ($urandom_range(0, 3) == 0);
        @(posedge clk);
        #1;
      end
    end

    // Drain everything and check beat conservation.
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);
    pulse_flush();
    idle(4);
    check("drain_out_valid", bus.out_valid, 0);
    check("beats_conserved", n_lanes, n_acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_byte_packer
